// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector.
// len_mask builds right-aligned ones for pattern masking.
package seq_det_pkg;

    localparam int MASK_W = 32;
    localparam logic [7:0] DEF_PATTERN_C = 8'h0B;
    localparam int DEF_LEN_C = 4;

    function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MASK_W; i++) begin
            if (i < len) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// clr and inc together load 1 so a same-cycle event is not lost.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = inc ? W'(1) : '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with overlap control,
// input qualifier and a saturating match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(DEF_PATTERN_C),
    parameter int DEF_LEN = DEF_LEN_C,
    localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               cnt_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_count
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               match_q, match_d;

    logic [MAX_LEN-1:0] hist_shift;
    logic [LEN_W-1:0]   fill_inc;
    logic [MAX_LEN-1:0] mask;
    logic               hit;

    assign hist_shift = {hist_q[MAX_LEN-2:0], in_bit};
    assign fill_inc = (fill_q == MAX_LEN_L) ? fill_q : fill_q + LEN_W'(1);
    assign mask = MAX_LEN'(len_mask(32'(len_q)));

    // Compare against the post-shift history so the final bit counts.
    assign hit = (len_q != '0) && (fill_inc >= len_q) &&
                 (((hist_shift ^ pattern_q) & mask) == '0);

    always_comb begin
        pattern_d = pattern_q;
        len_d = len_q;
        overlap_d = overlap_q;
        hist_d = hist_q;
        fill_d = fill_q;
        match_d = 1'b0;
        if (cfg_load) begin
            pattern_d = cfg_pattern;
            len_d = (cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;
            overlap_d = cfg_overlap;
            hist_d = '0;
            fill_d = '0;
        end else if (in_valid) begin
            hist_d = hist_shift;
            fill_d = fill_inc;
            match_d = hit;
            if (hit && !overlap_q) fill_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pattern_q <= DEF_PATTERN;
            len_q <= LEN_W'(DEF_LEN);
            overlap_q <= 1'b1;
            hist_q <= '0;
            fill_q <= '0;
            match_q <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            len_q <= len_d;
            overlap_q <= overlap_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            match_q <= match_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (match_d),
        .clr   (cnt_clr),
        .count (match_count)
    );

    assign match = match_q;

endmodule
